// File: rtl/pic_inta_sequencer.sv
// pic_inta_sequencer
//   Sequences the CPU interrupt-acknowledge handshake: raises INT on a
//   resolver request and counts INTA pulses (2 in 8086 mode, 3 in 8080 mode).
//   While it counts, it freezes the resolver, pulses the ISR set bit and drives
//   the CALL/vector bytes onto the internal data bus.
//   Optional cascade support is compiled in with `define PIC_CASCADE_EN.
module pic_inta_sequencer #(
    parameter int         INTA_SYNC    = 2,
    parameter logic [2:0] SPURIOUS_IDX = 3'd7
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       INTA,
    input  logic       INT_request,
    input  logic [2:0] interrupt_index,
    input  logic [7:0] ICW1,
    input  logic [7:0] ICW2,
    input  logic [7:0] ICW4,
    input  logic       init_start,
`ifdef PIC_CASCADE_EN
    input  logic       SP,
    input  logic [7:0] ICW3,
    input  logic [2:0] CAS_in,
    output logic [2:0] CAS_out,
    output logic       cas_oe,
`endif
    output logic       INT,
    output logic       freezing,
    output logic       INT_request_ACK,
    output logic [7:0] isr_set,
    output logic [7:0] aeoi_clear,
    output logic [7:0] data_out,
    output logic       data_oe,
    output logic       busy
);

    typedef enum logic [2:0] {
        IDLE, REQ, ACK1, GAP1, ACK2, GAP2, ACK3
    } state_t;

    localparam logic [7:0] CALL_OPCODE = 8'hCD;

    // Mode bits taken straight from the init words.
    logic upm, adi, aeoi;
    assign upm  = ICW4[0];
    assign aeoi = ICW4[1];
    assign adi  = ICW1[2];

    // Init-word bits this block does not interpret.
    logic unused_icw_bits;
    assign unused_icw_bits = ^{ICW1[4:3], ICW1[1:0], ICW4[7:2]};

    // Reset synchronizer: asserts immediately, releases on a clock edge.
    logic [1:0] rst_pipe_q;
    logic       rst_int;
    always_ff @(posedge clk or posedge reset) begin
        if (reset) rst_pipe_q <= 2'b11;
        else       rst_pipe_q <= {rst_pipe_q[0], 1'b0};
    end
    assign rst_int = rst_pipe_q[1];

    // INTA synchronizer plus one history flop for edge detection.
    logic [INTA_SYNC-1:0] inta_sync_q;
    logic                 inta_prev_q;
    always_ff @(posedge clk or posedge rst_int) begin
        if (rst_int) begin
            inta_sync_q <= '1;
            inta_prev_q <= 1'b1;
        end else begin
            inta_sync_q <= {inta_sync_q[INTA_SYNC-2:0], INTA};
            inta_prev_q <= inta_sync_q[INTA_SYNC-1];
        end
    end

    logic inta_s, inta_fall, inta_rise, inta_active;
    assign inta_s    = inta_sync_q[INTA_SYNC-1];
    assign inta_fall = inta_prev_q & ~inta_s;
    assign inta_rise = ~inta_prev_q & inta_s;
    // An acknowledge already travelling through the synchronizer keeps REQ
    // alive, so a request that vanishes under it becomes a spurious cycle.
    assign inta_active = ~(&{inta_sync_q, inta_prev_q});

    // A glitch that shows up as a one-cycle low on the synced value yields a
    // fall then a rise on consecutive cycles, so the FSM steps twice.

    state_t     state_q, state_d;
    logic [2:0] idx_q, idx_d;
    logic       spur_q, spur_d;
    logic       drive_q, drive_d;
    logic       int_q, int_d;
    logic       freezing_q, freezing_d;
    logic       ack_q, ack_d;
    logic [7:0] isr_set_q, isr_set_d;
    logic [7:0] aeoi_q, aeoi_d;
    logic [7:0] data_out_q, data_out_d;
    logic       data_oe_q, data_oe_d;
    logic       busy_q, busy_d;
    logic       call_en, finish;
    logic [7:0] vector_byte;
`ifdef PIC_CASCADE_EN
    logic [2:0] cas_out_q, cas_out_d;
    logic       cas_oe_q, cas_oe_d;
`endif

    // Second-acknowledge byte: 8086 vector or 8080 CALL address low byte.
    always_comb begin
        if (upm)      vector_byte = {ICW2[7:3], idx_q};
        else if (adi) vector_byte = {ICW1[7:5], idx_q, 2'b00};
        else          vector_byte = {ICW1[7:6], idx_q, 3'b000};
    end

    // Next-state and next-output logic; every output is registered below.
    always_comb begin
        // NOTE: every variable gets a default first so no path can infer a latch.
        state_d    = state_q;
        idx_d      = idx_q;
        spur_d     = spur_q;
        drive_d    = drive_q;
        int_d      = int_q;
        freezing_d = freezing_q;
        ack_d      = 1'b0;
        isr_set_d  = 8'h00;
        aeoi_d     = 8'h00;
        data_out_d = data_out_q;
        data_oe_d  = data_oe_q;
        call_en    = 1'b1;
        finish     = 1'b0;
`ifdef PIC_CASCADE_EN
        cas_out_d  = cas_out_q;
        cas_oe_d   = cas_oe_q;
`endif
        case (state_q)
            IDLE: begin
                if (INT_request) begin
                    state_d = REQ;
                    int_d   = 1'b1;
                end
            end
            REQ: begin
                if (inta_fall) begin
                    state_d    = ACK1;
                    spur_d     = ~INT_request;
                    idx_d      = INT_request ? interrupt_index : SPURIOUS_IDX;
                    ack_d      = 1'b1;
                    freezing_d = 1'b1;
                    if (INT_request) isr_set_d = 8'b1 << idx_d;
                    drive_d    = 1'b1;
`ifdef PIC_CASCADE_EN
                    if (SP) begin
                        if (ICW3[idx_d]) begin
                            // A slave below this IR supplies the vector.
                            drive_d   = 1'b0;
                            cas_oe_d  = 1'b1;
                            cas_out_d = idx_d;
                        end
                    end else begin
                        call_en = 1'b0;
                        drive_d = (CAS_in == ICW3[2:0]);
                    end
`endif
                    if (!upm && call_en) begin
                        data_oe_d  = 1'b1;
                        data_out_d = CALL_OPCODE;
                    end
                end else if (!INT_request && !inta_active) begin
                    state_d = IDLE;
                    int_d   = 1'b0;
                end
            end
            ACK1: begin
                if (inta_rise) begin
                    state_d    = GAP1;
                    data_oe_d  = 1'b0;
                    data_out_d = 8'h00;
                end
            end
            GAP1: begin
                if (inta_fall) begin
                    state_d    = ACK2;
                    data_oe_d  = drive_q;
                    data_out_d = drive_q ? vector_byte : 8'h00;
                end
            end
            ACK2: begin
                if (inta_rise) begin
                    if (upm) begin
                        finish = 1'b1;
                    end else begin
                        state_d    = GAP2;
                        data_oe_d  = 1'b0;
                        data_out_d = 8'h00;
                    end
                end
            end
            GAP2: begin
                if (inta_fall) begin
                    state_d    = ACK3;
                    data_oe_d  = drive_q;
                    data_out_d = drive_q ? ICW2 : 8'h00;
                end
            end
            ACK3: begin
                if (inta_rise) finish = 1'b1;
            end
            default: state_d = IDLE;
        endcase

        if (finish) begin
            state_d    = IDLE;
            int_d      = 1'b0;
            freezing_d = 1'b0;
            data_oe_d  = 1'b0;
            data_out_d = 8'h00;
            if (aeoi && !spur_q) aeoi_d = 8'b1 << idx_q;
`ifdef PIC_CASCADE_EN
            cas_oe_d   = 1'b0;
            cas_out_d  = 3'd0;
`endif
        end

        // Re-initialisation aborts any sequence silently.
        if (init_start) begin
            state_d    = IDLE;
            idx_d      = 3'd0;
            spur_d     = 1'b0;
            drive_d    = 1'b0;
            int_d      = 1'b0;
            freezing_d = 1'b0;
            ack_d      = 1'b0;
            isr_set_d  = 8'h00;
            aeoi_d     = 8'h00;
            data_out_d = 8'h00;
            data_oe_d  = 1'b0;
`ifdef PIC_CASCADE_EN
            cas_oe_d   = 1'b0;
            cas_out_d  = 3'd0;
`endif
        end

        busy_d = (state_d != IDLE);
    end

    // State, latched index and registered outputs.
    always_ff @(posedge clk or posedge rst_int) begin
        if (rst_int) begin
            state_q    <= IDLE;
            idx_q      <= 3'd0;
            spur_q     <= 1'b0;
            drive_q    <= 1'b0;
            int_q      <= 1'b0;
            freezing_q <= 1'b0;
            ack_q      <= 1'b0;
            isr_set_q  <= 8'h00;
            aeoi_q     <= 8'h00;
            data_out_q <= 8'h00;
            data_oe_q  <= 1'b0;
            busy_q     <= 1'b0;
`ifdef PIC_CASCADE_EN
            cas_out_q  <= 3'd0;
            cas_oe_q   <= 1'b0;
`endif
        end else begin
            // NOTE: non-blocking so every flop samples pre-edge values.
            state_q    <= state_d;
            idx_q      <= idx_d;
            spur_q     <= spur_d;
            drive_q    <= drive_d;
            int_q      <= int_d;
            freezing_q <= freezing_d;
            ack_q      <= ack_d;
            isr_set_q  <= isr_set_d;
            aeoi_q     <= aeoi_d;
            data_out_q <= data_out_d;
            data_oe_q  <= data_oe_d;
            busy_q     <= busy_d;
`ifdef PIC_CASCADE_EN
            cas_out_q  <= cas_out_d;
            cas_oe_q   <= cas_oe_d;
`endif
        end
    end

    assign INT             = int_q;
    assign freezing        = freezing_q;
    assign INT_request_ACK = ack_q;
    assign isr_set         = isr_set_q;
    assign aeoi_clear      = aeoi_q;
    assign data_out        = data_out_q;
    assign data_oe         = data_oe_q;
    assign busy            = busy_q;
`ifdef PIC_CASCADE_EN
    assign CAS_out         = cas_out_q;
    assign cas_oe          = cas_oe_q;
`endif

endmodule

// File: tb/tb_pic_inta_sequencer.sv
// tb_pic_inta_sequencer: directed self-checking bench for pic_inta_sequencer.
module tb_pic_inta_sequencer;

    localparam int SYNC = 2;

    logic       clk = 1'b0;
    logic       reset;
    logic       INTA;
    logic       INT_request;
    logic [2:0] interrupt_index;
    logic [7:0] ICW1, ICW2, ICW4;
    logic       init_start;
    logic       INT, freezing, INT_request_ACK, data_oe, busy;
    logic [7:0] isr_set, aeoi_clear, data_out;
`ifdef PIC_CASCADE_EN
    logic       SP;
    logic [7:0] ICW3;
    logic [2:0] CAS_in;
    logic [2:0] CAS_out;
    logic       cas_oe;
`endif

    int checks   = 0;
    int failures = 0;

    pic_inta_sequencer #(.INTA_SYNC(SYNC), .SPURIOUS_IDX(3'd7)) dut (
        .clk             (clk),
        .reset           (reset),
        .INTA            (INTA),
        .INT_request     (INT_request),
        .interrupt_index (interrupt_index),
        .ICW1            (ICW1),
        .ICW2            (ICW2),
        .ICW4            (ICW4),
        .init_start      (init_start),
`ifdef PIC_CASCADE_EN
        .SP              (SP),
        .ICW3            (ICW3),
        .CAS_in          (CAS_in),
        .CAS_out         (CAS_out),
        .cas_oe          (cas_oe),
`endif
        .INT             (INT),
        .freezing        (freezing),
        .INT_request_ACK (INT_request_ACK),
        .isr_set         (isr_set),
        .aeoi_clear      (aeoi_clear),
        .data_out        (data_out),
        .data_oe         (data_oe),
        .busy            (busy)
    );

    always #5 clk = ~clk;

    // One clock, then sample just after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drive the INTA pin and wait for the synchronizer + register latency.
    task automatic inta_edge(input logic v);
        INTA = v;
        repeat (SYNC + 1) @(posedge clk);
        #1;
    endtask

    // Raise a request, let it reach REQ, and take the first acknowledge.
    task automatic start_seq(input logic [2:0] idx);
        interrupt_index = idx;
        INT_request = 1'b1;
        tick();
        inta_edge(1'b0);
        INT_request = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        #12;
        checks++;
        if ({INT, freezing, INT_request_ACK, data_oe, busy, isr_set, aeoi_clear, data_out} !== '0) begin
            failures++;
            $display("FAIL reset_outputs got INT=%b frz=%b ack=%b oe=%b busy=%b isr=%h aeoi=%h d=%h want all 0",
                     INT, freezing, INT_request_ACK, data_oe, busy, isr_set, aeoi_clear, data_out);
        end
        reset = 1'b0;
        repeat (4) tick();
        checks++;
        if (busy !== 1'b0 || INT !== 1'b0) begin
            failures++;
            $display("FAIL reset_release got busy=%b INT=%b want 0 0", busy, INT);
        end
    endtask

    task automatic test_8086();
        ICW1 = 8'h00; ICW2 = 8'h40; ICW4 = 8'h01;
        interrupt_index = 3'd3;
        INT_request = 1'b1;
        tick();
        checks++;
        if (INT !== 1'b1 || busy !== 1'b1) begin
            failures++;
            $display("FAIL 8086_int_raise got INT=%b busy=%b want 1 1", INT, busy);
        end
        INTA = 1'b0;
        repeat (SYNC) @(posedge clk);
        #1;
        checks++;
        if (INT_request_ACK !== 1'b0) begin
            failures++;
            $display("FAIL 8086_latency_early got ack=%b want 0", INT_request_ACK);
        end
        tick();
        checks++;
        if (INT_request_ACK !== 1'b1 || isr_set !== 8'h08 || freezing !== 1'b1 || data_oe !== 1'b0) begin
            failures++;
            $display("FAIL 8086_ack1 got ack=%b isr=%h frz=%b oe=%b want 1 08 1 0",
                     INT_request_ACK, isr_set, freezing, data_oe);
        end
        tick();
        checks++;
        if (isr_set !== 8'h00 || INT_request_ACK !== 1'b0) begin
            failures++;
            $display("FAIL 8086_isr_once got isr=%h ack=%b want 00 0", isr_set, INT_request_ACK);
        end
        INT_request = 1'b0;
        inta_edge(1'b1);
        checks++;
        if (INT !== 1'b1 || data_oe !== 1'b0 || busy !== 1'b1) begin
            failures++;
            $display("FAIL 8086_gap1 got INT=%b oe=%b busy=%b want 1 0 1", INT, data_oe, busy);
        end
        inta_edge(1'b0);
        checks++;
        if (data_oe !== 1'b1 || data_out !== 8'h43) begin
            failures++;
            $display("FAIL 8086_ack2 got oe=%b d=%h want 1 43", data_oe, data_out);
        end
        inta_edge(1'b1);
        checks++;
        if (INT !== 1'b0 || freezing !== 1'b0 || data_oe !== 1'b0 || busy !== 1'b0 || aeoi_clear !== 8'h00) begin
            failures++;
            $display("FAIL 8086_finish got INT=%b frz=%b oe=%b busy=%b aeoi=%h want 0 0 0 0 00",
                     INT, freezing, data_oe, busy, aeoi_clear);
        end
    endtask

    task automatic test_8080_adi1();
        ICW1 = 8'hE4; ICW2 = 8'h12; ICW4 = 8'h00;
        start_seq(3'd5);
        checks++;
        if (data_oe !== 1'b1 || data_out !== 8'hCD || isr_set !== 8'h20) begin
            failures++;
            $display("FAIL 8080_call got oe=%b d=%h isr=%h want 1 cd 20", data_oe, data_out, isr_set);
        end
        inta_edge(1'b1);
        checks++;
        if (data_oe !== 1'b0) begin
            failures++;
            $display("FAIL 8080_gap1 got oe=%b want 0", data_oe);
        end
        inta_edge(1'b0);
        checks++;
        if (data_oe !== 1'b1 || data_out !== 8'hF4) begin
            failures++;
            $display("FAIL 8080_low_addr got oe=%b d=%h want 1 f4", data_oe, data_out);
        end
        inta_edge(1'b1);
        checks++;
        if (data_oe !== 1'b0 || busy !== 1'b1 || INT !== 1'b1) begin
            failures++;
            $display("FAIL 8080_gap2 got oe=%b busy=%b INT=%b want 0 1 1", data_oe, busy, INT);
        end
        inta_edge(1'b0);
        checks++;
        if (data_oe !== 1'b1 || data_out !== 8'h12) begin
            failures++;
            $display("FAIL 8080_high_addr got oe=%b d=%h want 1 12", data_oe, data_out);
        end
        inta_edge(1'b1);
        checks++;
        if (data_oe !== 1'b0 || busy !== 1'b0 || INT !== 1'b0) begin
            failures++;
            $display("FAIL 8080_finish got oe=%b busy=%b INT=%b want 0 0 0", data_oe, busy, INT);
        end
    endtask

    task automatic test_8080_adi0();
        ICW1 = 8'hC0; ICW2 = 8'h12; ICW4 = 8'h00;
        start_seq(3'd1);
        inta_edge(1'b1);
        inta_edge(1'b0);
        checks++;
        if (data_oe !== 1'b1 || data_out !== 8'hC8) begin
            failures++;
            $display("FAIL 8080_adi0_addr got oe=%b d=%h want 1 c8", data_oe, data_out);
        end
        inta_edge(1'b1);
        inta_edge(1'b0);
        inta_edge(1'b1);
        checks++;
        if (busy !== 1'b0) begin
            failures++;
            $display("FAIL 8080_adi0_finish got busy=%b want 0", busy);
        end
    endtask

    task automatic test_aeoi();
        ICW1 = 8'h00; ICW2 = 8'h40; ICW4 = 8'h03;
        start_seq(3'd6);
        checks++;
        if (isr_set !== 8'h40) begin
            failures++;
            $display("FAIL aeoi_isr got isr=%h want 40", isr_set);
        end
        inta_edge(1'b1);
        inta_edge(1'b0);
        checks++;
        if (aeoi_clear !== 8'h00) begin
            failures++;
            $display("FAIL aeoi_early got aeoi=%h want 00", aeoi_clear);
        end
        inta_edge(1'b1);
        checks++;
        if (aeoi_clear !== 8'h40) begin
            failures++;
            $display("FAIL aeoi_pulse got aeoi=%h want 40", aeoi_clear);
        end
        tick();
        checks++;
        if (aeoi_clear !== 8'h00) begin
            failures++;
            $display("FAIL aeoi_one_cycle got aeoi=%h want 00", aeoi_clear);
        end
    endtask

    task automatic test_request_drop();
        ICW1 = 8'h00; ICW2 = 8'h40; ICW4 = 8'h03;
        interrupt_index = 3'd2;
        INT_request = 1'b1;
        tick();
        INT_request = 1'b0;
        tick();
        checks++;
        if (INT !== 1'b0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL req_drop got INT=%b busy=%b want 0 0", INT, busy);
        end
        // Request held until the INTA pin falls, then withdrawn.
        INT_request = 1'b1;
        tick();
        INTA = 1'b0;
        tick();
        INT_request = 1'b0;
        repeat (SYNC) @(posedge clk);
        #1;
        checks++;
        if (INT_request_ACK !== 1'b1 || isr_set !== 8'h00 || INT !== 1'b1) begin
            failures++;
            $display("FAIL spurious_ack got ack=%b isr=%h INT=%b want 1 00 1", INT_request_ACK, isr_set, INT);
        end
        inta_edge(1'b1);
        inta_edge(1'b0);
        checks++;
        if (data_out !== 8'h47 || data_oe !== 1'b1) begin
            failures++;
            $display("FAIL spurious_vector got d=%h oe=%b want 47 1", data_out, data_oe);
        end
        inta_edge(1'b1);
        checks++;
        if (aeoi_clear !== 8'h00 || busy !== 1'b0) begin
            failures++;
            $display("FAIL spurious_no_aeoi got aeoi=%h busy=%b want 00 0", aeoi_clear, busy);
        end
    endtask

    task automatic test_abort();
        ICW1 = 8'h00; ICW2 = 8'h40; ICW4 = 8'h01;
        start_seq(3'd3);
        inta_edge(1'b1);
        inta_edge(1'b0);
        init_start = 1'b1;
        tick();
        init_start = 1'b0;
        checks++;
        if (data_oe !== 1'b0 || INT !== 1'b0 || freezing !== 1'b0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL init_abort got oe=%b INT=%b frz=%b busy=%b want 0 0 0 0", data_oe, INT, freezing, busy);
        end
        // Stray INTA activity in IDLE must not drive the bus.
        inta_edge(1'b1);
        inta_edge(1'b0);
        checks++;
        if (data_oe !== 1'b0 || busy !== 1'b0 || INT_request_ACK !== 1'b0) begin
            failures++;
            $display("FAIL idle_inta got oe=%b busy=%b ack=%b want 0 0 0", data_oe, busy, INT_request_ACK);
        end
        inta_edge(1'b1);
        start_seq(3'd3);
        inta_edge(1'b1);
        inta_edge(1'b0);
        reset = 1'b1;
        #1;
        checks++;
        if (data_oe !== 1'b0 || INT !== 1'b0 || freezing !== 1'b0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL reset_abort got oe=%b INT=%b frz=%b busy=%b want 0 0 0 0", data_oe, INT, freezing, busy);
        end
        INTA = 1'b1;
        tick();
        reset = 1'b0;
        repeat (4) tick();
    endtask

`ifdef PIC_CASCADE_EN
    task automatic test_cascade_master();
        SP = 1'b1; ICW3 = 8'h04;
        ICW1 = 8'h00; ICW2 = 8'h40; ICW4 = 8'h01;
        start_seq(3'd2);
        checks++;
        if (cas_oe !== 1'b1 || CAS_out !== 3'd2) begin
            failures++;
            $display("FAIL cas_ack1 got cas_oe=%b cas=%0d want 1 2", cas_oe, CAS_out);
        end
        inta_edge(1'b1);
        inta_edge(1'b0);
        checks++;
        if (data_oe !== 1'b0 || cas_oe !== 1'b1) begin
            failures++;
            $display("FAIL cas_ack2 got oe=%b cas_oe=%b want 0 1", data_oe, cas_oe);
        end
        inta_edge(1'b1);
        checks++;
        if (cas_oe !== 1'b0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL cas_finish got cas_oe=%b busy=%b want 0 0", cas_oe, busy);
        end
        ICW3 = 8'h00;
    endtask
`endif

    initial begin
        INTA = 1'b1; INT_request = 1'b0; interrupt_index = 3'd0;
        ICW1 = 8'h00; ICW2 = 8'h00; ICW4 = 8'h00; init_start = 1'b0;
`ifdef PIC_CASCADE_EN
        SP = 1'b1; ICW3 = 8'h00; CAS_in = 3'd0;
`endif
        test_reset();
        test_8086();
        test_8080_adi1();
        test_8080_adi0();
        test_aeoi();
        test_request_drop();
        test_abort();
`ifdef PIC_CASCADE_EN
        test_cascade_master();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
